// File: rtl/ulpi_pkg.sv
// ------------------------------------------------------------------
// ulpi_pkg : shared types, ULPI register addresses and the PHY
//            init table used by the ULPI register arbiter.
// Rev 1.0
// ------------------------------------------------------------------
`default_nettype none

package ulpi_pkg;

    typedef enum logic [2:0] {
        INIT_WAIT  = 3'd0,
        INIT_ISSUE = 3'd1,
        INIT_BUSY  = 3'd2,
        IDLE       = 3'd3,
        ISSUE      = 3'd4,
        BUSY       = 3'd5,
        RESP       = 3'd6,
        HALT       = 3'd7
    } arb_state_e;

    typedef struct packed {
        logic       rw;
        logic [5:0] addr;
        logic [7:0] wdata;
    } reg_op_t;

    localparam logic [5:0] FUNC_CTRL = 6'h04;
    localparam logic [5:0] OTG_CTRL  = 6'h0A;
    localparam logic [5:0] IFC_CTRL  = 6'h07;

    localparam logic [7:0] FUNC_CTRL_INIT = 8'h45;
    localparam logic [7:0] OTG_CTRL_INIT  = 8'h06;
    localparam logic [7:0] IFC_CTRL_INIT  = 8'h00;

    localparam logic [1:0] INIT_LAST_IDX = 2'd2;

    // Init entries are always register writes.
    function automatic reg_op_t init_entry(input logic [1:0] idx);
        reg_op_t op;
        op.rw = 1'b1;
        case (idx)
            2'd0:    begin op.addr = FUNC_CTRL; op.wdata = FUNC_CTRL_INIT; end
            2'd1:    begin op.addr = OTG_CTRL;  op.wdata = OTG_CTRL_INIT;  end
            default: begin op.addr = IFC_CTRL;  op.wdata = IFC_CTRL_INIT;  end
        endcase
        return op;
    endfunction

endpackage

`default_nettype wire

// File: rtl/ulpi_reg_arbiter_if.sv
// ------------------------------------------------------------------
// ulpi_reg_arbiter_if : ULPI register-access bus between the
//                       arbiter (master) and the ULPI block (slave).
// Rev 1.0
// ------------------------------------------------------------------
`default_nettype none

interface ulpi_reg_arbiter_if;

    logic       ULPI_READY;
    logic       ULPI_REG_EN;
    logic       ULPI_REG_RW;
    logic [5:0] ULPI_REG_ADDR;
    logic [7:0] ULPI_REG_WDATA;
    logic [7:0] ULPI_REG_RDATA;
    logic       ULPI_REG_DONE;
    logic       ULPI_REG_FAIL;

    modport master (
        input  ULPI_READY,
        input  ULPI_REG_RDATA,
        input  ULPI_REG_DONE,
        input  ULPI_REG_FAIL,
        output ULPI_REG_EN,
        output ULPI_REG_RW,
        output ULPI_REG_ADDR,
        output ULPI_REG_WDATA
    );

    modport slave (
        output ULPI_READY,
        output ULPI_REG_RDATA,
        output ULPI_REG_DONE,
        output ULPI_REG_FAIL,
        input  ULPI_REG_EN,
        input  ULPI_REG_RW,
        input  ULPI_REG_ADDR,
        input  ULPI_REG_WDATA
    );

endinterface

`default_nettype wire

// File: rtl/ulpi_rr_arb.sv
// ------------------------------------------------------------------
// ulpi_rr_arb : two-way round-robin grant; the pointer moves only
//               when the owner actually accepts a grant.
// Rev 1.0
// ------------------------------------------------------------------
`default_nettype none

module ulpi_rr_arb (
    input  wire logic clk_i,
    input  wire logic rst_i,
    input  wire logic req_a_i,
    input  wire logic req_b_i,
    input  wire logic update_i,
    output logic      gnt_a_o,
    output logic      gnt_b_o
);

    logic prio_b_q;
    logic prio_b_d;

    always_comb begin
        gnt_a_o  = req_a_i && (!req_b_i || !prio_b_q);
        gnt_b_o  = req_b_i && (!req_a_i ||  prio_b_q);
        prio_b_d = prio_b_q;
        if (update_i && (gnt_a_o || gnt_b_o)) begin
            prio_b_d = gnt_a_o;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            prio_b_q <= 1'b0;
        end else begin
            prio_b_q <= prio_b_d;
        end
    end

endmodule

`default_nettype wire

// File: rtl/ulpi_reg_arbiter.sv
// ------------------------------------------------------------------
// ulpi_reg_arbiter : runs the PHY init table, then shares the ULPI
//                    register port between requesters A and B.
// Rev 1.0
// ------------------------------------------------------------------
`default_nettype none

module ulpi_reg_arbiter
    import ulpi_pkg::*;
#(
    parameter int MAX_RETRY = 3,
    parameter int TIMEOUT   = 255
) (
    input  wire logic        CLK_60M,
    input  wire logic        RST_A_USB,
    ulpi_reg_arbiter_if.master ulpi,
    input  wire logic        A_REQ,
    input  wire logic        A_RW,
    input  wire logic [5:0]  A_ADDR,
    input  wire logic [7:0]  A_WDATA,
    input  wire logic        B_REQ,
    input  wire logic        B_RW,
    input  wire logic [5:0]  B_ADDR,
    input  wire logic [7:0]  B_WDATA,
    output logic             A_ACK,
    output logic             A_ERR,
    output logic             B_ACK,
    output logic             B_ERR,
    output logic [7:0]       RDATA,
    output logic             INIT_DONE,
    output logic             INIT_FAIL
);

    localparam logic [7:0] C_TIMEOUT   = 8'(TIMEOUT);
    localparam logic [7:0] C_MAX_RETRY = 8'(MAX_RETRY);

    arb_state_e state_q, state_d;
    reg_op_t    hold_q, hold_d;
    logic [1:0] idx_q, idx_d;
    logic [7:0] tmo_q, tmo_d;
    logic [7:0] retry_q, retry_d;
    logic       wait_q, wait_d;
    logic       own_b_q, own_b_d;
    logic       err_q, err_d;
    logic [7:0] rdata_q, rdata_d;
    logic       init_done_q, init_done_d;
    logic       init_fail_q, init_fail_d;
    logic       done_prev_q;
    logic       fail_prev_q;

    logic       w_grant;
    logic       w_gnt_a;
    logic       w_gnt_b;
    logic [7:0] w_tmo_inc;
    logic       w_timeout;
    logic       w_done_rise;
    logic       w_fail_rise;
    logic       w_attempt_fail;
    logic       w_can_retry;

    assign w_grant = (state_q == IDLE) && ulpi.ULPI_READY && (A_REQ || B_REQ);

    ulpi_rr_arb u_rr_arb (
        .clk_i    (CLK_60M),
        .rst_i    (RST_A_USB),
        .req_a_i  (A_REQ),
        .req_b_i  (B_REQ),
        .update_i (w_grant),
        .gnt_a_o  (w_gnt_a),
        .gnt_b_o  (w_gnt_b)
    );

    // A DONE rising together with FAIL is treated as a failed attempt.
    assign w_done_rise    = ulpi.ULPI_REG_DONE && !done_prev_q;
    assign w_fail_rise    = ulpi.ULPI_REG_FAIL && !fail_prev_q;
    assign w_tmo_inc      = (tmo_q == 8'hFF) ? tmo_q : tmo_q + 8'd1;
    assign w_timeout      = (w_tmo_inc == C_TIMEOUT);
    assign w_attempt_fail = w_fail_rise || w_timeout;
    assign w_can_retry    = (retry_q < C_MAX_RETRY);

    always_comb begin
        state_d     = state_q;
        hold_d      = hold_q;
        idx_d       = idx_q;
        tmo_d       = tmo_q;
        retry_d     = retry_q;
        wait_d      = wait_q;
        own_b_d     = own_b_q;
        err_d       = err_q;
        rdata_d     = rdata_q;
        init_done_d = init_done_q;
        init_fail_d = init_fail_q;

        case (state_q)
            INIT_WAIT: begin
                if (ulpi.ULPI_READY) begin
                    hold_d  = init_entry(idx_q);
                    state_d = INIT_ISSUE;
                end
            end

            INIT_ISSUE: begin
                tmo_d   = 8'd0;
                state_d = INIT_BUSY;
            end

            INIT_BUSY: begin
                tmo_d = w_tmo_inc;
                if (w_attempt_fail) begin
                    if (w_can_retry) begin
                        retry_d = retry_q + 8'd1;
                        state_d = INIT_WAIT;
                    end else begin
                        init_fail_d = 1'b1;
                        state_d     = HALT;
                    end
                end else if (w_done_rise) begin
                    retry_d = 8'd0;
                    if (idx_q == INIT_LAST_IDX) begin
                        idx_d       = 2'd0;
                        init_done_d = 1'b1;
                        state_d     = IDLE;
                    end else begin
                        idx_d   = idx_q + 2'd1;
                        state_d = INIT_WAIT;
                    end
                end
            end

            IDLE: begin
                if (w_grant) begin
                    if (w_gnt_b) begin
                        hold_d = '{rw: B_RW, addr: B_ADDR, wdata: B_WDATA};
                    end else begin
                        hold_d = '{rw: A_RW, addr: A_ADDR, wdata: A_WDATA};
                    end
                    own_b_d = w_gnt_b;
                    retry_d = 8'd0;
                    tmo_d   = 8'd0;
                    err_d   = 1'b0;
                    state_d = ISSUE;
                end
            end

            ISSUE: begin
                tmo_d   = 8'd0;
                wait_d  = 1'b0;
                state_d = BUSY;
            end

            BUSY: begin
                // After a failed attempt the re-issue waits here for READY.
                if (wait_q) begin
                    if (ulpi.ULPI_READY) begin
                        wait_d  = 1'b0;
                        state_d = ISSUE;
                    end
                end else begin
                    tmo_d = w_tmo_inc;
                    if (w_attempt_fail) begin
                        if (w_can_retry) begin
                            retry_d = retry_q + 8'd1;
                            if (ulpi.ULPI_READY) begin
                                state_d = ISSUE;
                            end else begin
                                wait_d = 1'b1;
                            end
                        end else begin
                            err_d   = 1'b1;
                            rdata_d = 8'h00;
                            state_d = RESP;
                        end
                    end else if (w_done_rise) begin
                        err_d   = 1'b0;
                        rdata_d = hold_q.rw ? 8'h00 : ulpi.ULPI_REG_RDATA;
                        state_d = RESP;
                    end
                end
            end

            RESP: begin
                state_d = IDLE;
            end

            HALT: begin
                state_d = HALT;
            end

            default: begin
                state_d = INIT_WAIT;
            end
        endcase
    end

    always_ff @(posedge CLK_60M or posedge RST_A_USB) begin
        if (RST_A_USB) begin
            state_q     <= INIT_WAIT;
            hold_q      <= '0;
            idx_q       <= 2'd0;
            tmo_q       <= 8'd0;
            retry_q     <= 8'd0;
            wait_q      <= 1'b0;
            own_b_q     <= 1'b0;
            err_q       <= 1'b0;
            rdata_q     <= 8'h00;
            init_done_q <= 1'b0;
            init_fail_q <= 1'b0;
            done_prev_q <= 1'b0;
            fail_prev_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            hold_q      <= hold_d;
            idx_q       <= idx_d;
            tmo_q       <= tmo_d;
            retry_q     <= retry_d;
            wait_q      <= wait_d;
            own_b_q     <= own_b_d;
            err_q       <= err_d;
            rdata_q     <= rdata_d;
            init_done_q <= init_done_d;
            init_fail_q <= init_fail_d;
            done_prev_q <= ulpi.ULPI_REG_DONE;
            fail_prev_q <= ulpi.ULPI_REG_FAIL;
        end
    end

    assign ulpi.ULPI_REG_EN    = (state_q == ISSUE) || (state_q == INIT_ISSUE);
    assign ulpi.ULPI_REG_RW    = hold_q.rw;
    assign ulpi.ULPI_REG_ADDR  = hold_q.addr;
    assign ulpi.ULPI_REG_WDATA = hold_q.wdata;

    assign A_ACK     = (state_q == RESP) && !err_q && !own_b_q;
    assign A_ERR     = (state_q == RESP) &&  err_q && !own_b_q;
    assign B_ACK     = (state_q == RESP) && !err_q &&  own_b_q;
    assign B_ERR     = (state_q == RESP) &&  err_q &&  own_b_q;
    assign RDATA     = rdata_q;
    assign INIT_DONE = init_done_q;
    assign INIT_FAIL = init_fail_q;

endmodule

`default_nettype wire

// File: tb/tb_ulpi_reg_arbiter.sv
// ------------------------------------------------------------------
// tb_ulpi_reg_arbiter : directed bench with a small ULPI block model.
// Rev 1.0
// ------------------------------------------------------------------
`default_nettype none

module tb_ulpi_reg_arbiter;

    logic       CLK_60M   = 1'b0;
    logic       RST_A_USB = 1'b0;
    logic       A_REQ = 1'b0, A_RW = 1'b0, B_REQ = 1'b0, B_RW = 1'b0;
    logic [5:0] A_ADDR = '0, B_ADDR = '0;
    logic [7:0] A_WDATA = '0, B_WDATA = '0;
    logic       A_ACK, A_ERR, B_ACK, B_ERR, INIT_DONE, INIT_FAIL;
    logic [7:0] RDATA;

    always #8 CLK_60M = ~CLK_60M;

    ulpi_reg_arbiter_if u_if ();

    ulpi_reg_arbiter #(.MAX_RETRY(3), .TIMEOUT(255)) u_dut (
        .CLK_60M   (CLK_60M),
        .RST_A_USB (RST_A_USB),
        .ulpi      (u_if.master),
        .A_REQ     (A_REQ),
        .A_RW      (A_RW),
        .A_ADDR    (A_ADDR),
        .A_WDATA   (A_WDATA),
        .B_REQ     (B_REQ),
        .B_RW      (B_RW),
        .B_ADDR    (B_ADDR),
        .B_WDATA   (B_WDATA),
        .A_ACK     (A_ACK),
        .A_ERR     (A_ERR),
        .B_ACK     (B_ACK),
        .B_ERR     (B_ERR),
        .RDATA     (RDATA),
        .INIT_DONE (INIT_DONE),
        .INIT_FAIL (INIT_FAIL)
    );

    int n_vec = 0;
    int n_bad = 0;

    // Model configuration, written only by the stimulus process.
    bit         cfg_silent    = 1'b0;
    int         cfg_gen       = 0;
    logic [5:0] cfg_fail_addr = 6'h3F;
    int         cfg_fail_n    = 0;

    // Model state and log, written only by the model process.
    int         cyc = 0;
    int         en_n = 0;
    logic [5:0] en_addr  [64];
    logic [7:0] en_wdata [64];
    logic       en_rw    [64];
    int         en_cyc   [64];
    int         a_ack_n = 0, a_err_n = 0, b_ack_n = 0, b_err_n = 0;
    logic [7:0] a_rd = '0, b_rd = '0;
    int         a_resp_cyc = 0;
    int         viol_n = 0;
    logic       en_prev = 1'b0;
    int         countdown = 0;
    logic [5:0] pend_addr = '0;
    int         seen_gen = 0, fail_used = 0;

    // ULPI block model: answers 3 cycles after each REG_EN unless silent.
    initial begin
        u_if.ULPI_READY     = 1'b1;
        u_if.ULPI_REG_DONE  = 1'b0;
        u_if.ULPI_REG_FAIL  = 1'b0;
        u_if.ULPI_REG_RDATA = 8'h00;
        forever begin
            @(posedge CLK_60M);
            #1;
            cyc++;
            u_if.ULPI_REG_DONE = 1'b0;
            u_if.ULPI_REG_FAIL = 1'b0;
            if (cfg_gen != seen_gen) begin
                seen_gen  = cfg_gen;
                fail_used = 0;
            end
            if (RST_A_USB) countdown = 0;
            if (countdown > 0) begin
                countdown--;
                if (countdown == 0) begin
                    if (pend_addr == cfg_fail_addr && fail_used < cfg_fail_n) begin
                        u_if.ULPI_REG_FAIL = 1'b1;
                        fail_used++;
                    end else begin
                        u_if.ULPI_REG_DONE  = 1'b1;
                        u_if.ULPI_REG_RDATA = (pend_addr == 6'h00) ? 8'h24 :
                                              (pend_addr == 6'h01) ? 8'h04 : 8'h00;
                    end
                end
            end
            if (u_if.ULPI_REG_EN === 1'b1) begin
                if (en_n < 64) begin
                    en_addr[en_n]  = u_if.ULPI_REG_ADDR;
                    en_wdata[en_n] = u_if.ULPI_REG_WDATA;
                    en_rw[en_n]    = u_if.ULPI_REG_RW;
                    en_cyc[en_n]   = cyc;
                end
                en_n++;
                pend_addr = u_if.ULPI_REG_ADDR;
                if (!cfg_silent) countdown = 3;
                if (en_prev) viol_n++;
            end
            en_prev = (u_if.ULPI_REG_EN === 1'b1);
            if (A_ACK === 1'b1) begin a_ack_n++; a_rd = RDATA; a_resp_cyc = cyc; end
            if (A_ERR === 1'b1) begin a_err_n++; a_rd = RDATA; a_resp_cyc = cyc; end
            if (B_ACK === 1'b1) begin b_ack_n++; b_rd = RDATA; end
            if (B_ERR === 1'b1) begin b_err_n++; b_rd = RDATA; end
            if ((A_ACK && A_ERR) || (B_ACK && B_ERR) || ((A_ACK || A_ERR) && (B_ACK || B_ERR)))
                viol_n++;
        end
    end

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge CLK_60M);
            #2;
        end
    endtask

    task automatic wait_init_done(input string tag);
        int i;
        for (i = 0; i < 300 && INIT_DONE !== 1'b1; i++) tick(1);
        n_vec++;
        if (INIT_DONE !== 1'b1) begin
            n_bad++;
            $display("FAIL %s_init_done: got %b want 1", tag, INIT_DONE);
        end
    endtask

    task automatic test_reset();
        tick(1);
        RST_A_USB = 1'b1;
        tick(3);
        n_vec++;
        if ({u_if.ULPI_REG_EN, u_if.ULPI_REG_RW, u_if.ULPI_REG_ADDR, u_if.ULPI_REG_WDATA} !== 16'h0) begin
            n_bad++;
            $display("FAIL reset_bus: got en=%b rw=%b addr=%h wdata=%h want all 0",
                     u_if.ULPI_REG_EN, u_if.ULPI_REG_RW, u_if.ULPI_REG_ADDR, u_if.ULPI_REG_WDATA);
        end
        n_vec++;
        if ({A_ACK, A_ERR, B_ACK, B_ERR, INIT_DONE, INIT_FAIL, RDATA} !== 14'h0) begin
            n_bad++;
            $display("FAIL reset_outputs: got ack/err=%b%b%b%b done=%b fail=%b rdata=%h want all 0",
                     A_ACK, A_ERR, B_ACK, B_ERR, INIT_DONE, INIT_FAIL, RDATA);
        end
    endtask

    task automatic test_init();
        logic [5:0] exp_addr  [3] = '{6'h04, 6'h0A, 6'h07};
        logic [7:0] exp_wdata [3] = '{8'h45, 8'h06, 8'h00};
        int base = en_n;
        RST_A_USB = 1'b0;
        wait_init_done("init");
        n_vec++;
        if (en_n - base != 3) begin
            n_bad++;
            $display("FAIL init_en_count: got %0d want 3", en_n - base);
        end
        for (int k = 0; k < 3; k++) begin
            n_vec++;
            if ({en_rw[base+k], en_addr[base+k], en_wdata[base+k]} !== {1'b1, exp_addr[k], exp_wdata[k]}) begin
                n_bad++;
                $display("FAIL init_entry%0d: got rw=%b addr=%h wdata=%h want rw=1 addr=%h wdata=%h", k,
                         en_rw[base+k], en_addr[base+k], en_wdata[base+k], exp_addr[k], exp_wdata[k]);
            end
        end
        n_vec++;
        if (INIT_FAIL !== 1'b0) begin
            n_bad++;
            $display("FAIL init_fail_flag: got %b want 0", INIT_FAIL);
        end
    endtask

    task automatic test_round_robin();
        int a0 = a_ack_n, b0 = b_ack_n;
        int first = 0;
        A_RW = 1'b0; A_ADDR = 6'h00; A_REQ = 1'b1;
        B_RW = 1'b0; B_ADDR = 6'h01; B_REQ = 1'b1;
        for (int i = 0; i < 200 && (A_REQ || B_REQ); i++) begin
            tick(1);
            if (A_ACK === 1'b1) begin
                if (first == 0) first = 1;
                n_vec++;
                if (RDATA !== 8'h24) begin
                    n_bad++;
                    $display("FAIL rr_a_rdata: got %h want 24", RDATA);
                end
                A_REQ = 1'b0;
            end
            if (B_ACK === 1'b1) begin
                if (first == 0) first = 2;
                n_vec++;
                if (RDATA !== 8'h04) begin
                    n_bad++;
                    $display("FAIL rr_b_rdata: got %h want 04", RDATA);
                end
                B_REQ = 1'b0;
            end
        end
        A_REQ = 1'b0; B_REQ = 1'b0;
        tick(2);
        n_vec++;
        if (first != 1) begin
            n_bad++;
            $display("FAIL rr_order: got first=%0d want 1 (A)", first);
        end
        n_vec++;
        if (a_ack_n - a0 != 1 || b_ack_n - b0 != 1) begin
            n_bad++;
            $display("FAIL rr_ack_count: got a=%0d b=%0d want 1 1", a_ack_n - a0, b_ack_n - b0);
        end
    endtask

    task automatic test_retry();
        int base = en_n, a0 = a_ack_n, e0 = a_err_n;
        cfg_fail_addr = 6'h16; cfg_fail_n = 2; cfg_gen++;
        A_RW = 1'b1; A_ADDR = 6'h16; A_WDATA = 8'h55; A_REQ = 1'b1;
        for (int i = 0; i < 200 && A_REQ; i++) begin
            tick(1);
            if (A_ACK === 1'b1 || A_ERR === 1'b1) A_REQ = 1'b0;
        end
        A_REQ = 1'b0;
        tick(2);
        cfg_fail_n = 0; cfg_gen++;
        n_vec++;
        if (en_n - base != 3) begin
            n_bad++;
            $display("FAIL retry_en_count: got %0d want 3", en_n - base);
        end
        n_vec++;
        if ({en_rw[base+2], en_addr[base+2], en_wdata[base+2]} !== {1'b1, 6'h16, 8'h55}) begin
            n_bad++;
            $display("FAIL retry_fields: got rw=%b addr=%h wdata=%h want 1 16 55",
                     en_rw[base+2], en_addr[base+2], en_wdata[base+2]);
        end
        n_vec++;
        if (a_ack_n - a0 != 1 || a_err_n - e0 != 0 || a_rd !== 8'h00) begin
            n_bad++;
            $display("FAIL retry_resp: got ack=%0d err=%0d rdata=%h want 1 0 00",
                     a_ack_n - a0, a_err_n - e0, a_rd);
        end
    endtask

    task automatic test_timeout();
        int base = en_n, a0 = a_ack_n, e0 = a_err_n;
        cfg_silent = 1'b1;
        A_RW = 1'b0; A_ADDR = 6'h01; A_REQ = 1'b1;
        for (int i = 0; i < 1500 && A_REQ; i++) begin
            tick(1);
            if (A_ACK === 1'b1 || A_ERR === 1'b1) A_REQ = 1'b0;
        end
        A_REQ = 1'b0;
        cfg_silent = 1'b0;
        tick(2);
        n_vec++;
        if (en_n - base != 4) begin
            n_bad++;
            $display("FAIL tmo_en_count: got %0d want 4", en_n - base);
        end
        for (int k = 0; k < 3; k++) begin
            n_vec++;
            if (en_cyc[base+k+1] - en_cyc[base+k] != 256) begin
                n_bad++;
                $display("FAIL tmo_gap%0d: got %0d want 256", k, en_cyc[base+k+1] - en_cyc[base+k]);
            end
        end
        n_vec++;
        if (a_err_n - e0 != 1 || a_ack_n - a0 != 0 || a_rd !== 8'h00) begin
            n_bad++;
            $display("FAIL tmo_resp: got err=%0d ack=%0d rdata=%h want 1 0 00",
                     a_err_n - e0, a_ack_n - a0, a_rd);
        end
        n_vec++;
        if (a_resp_cyc - en_cyc[base+3] != 256) begin
            n_bad++;
            $display("FAIL tmo_err_latency: got %0d want 256", a_resp_cyc - en_cyc[base+3]);
        end
    endtask

    task automatic test_reset_midop();
        int base = en_n, b0 = b_ack_n, e0 = b_err_n, base2;
        cfg_silent = 1'b1;
        B_RW = 1'b1; B_ADDR = 6'h05; B_WDATA = 8'hAA; B_REQ = 1'b1;
        for (int i = 0; i < 50 && en_n == base; i++) tick(1);
        tick(10);
        #3 RST_A_USB = 1'b1;
        #1;
        n_vec++;
        if ({u_if.ULPI_REG_EN, u_if.ULPI_REG_ADDR, B_ACK, B_ERR, INIT_DONE} !== 10'h0) begin
            n_bad++;
            $display("FAIL midrst_async: got en=%b addr=%h back=%b berr=%b done=%b want all 0",
                     u_if.ULPI_REG_EN, u_if.ULPI_REG_ADDR, B_ACK, B_ERR, INIT_DONE);
        end
        B_REQ = 1'b0;
        cfg_silent = 1'b0;
        tick(3);
        base2 = en_n;
        RST_A_USB = 1'b0;
        wait_init_done("midrst");
        n_vec++;
        if (b_ack_n - b0 != 0 || b_err_n - e0 != 0) begin
            n_bad++;
            $display("FAIL midrst_no_resp: got ack=%0d err=%0d want 0 0", b_ack_n - b0, b_err_n - e0);
        end
        n_vec++;
        if (en_n - base2 != 3 || en_addr[base2] !== 6'h04 || en_wdata[base2] !== 8'h45) begin
            n_bad++;
            $display("FAIL midrst_reinit: got count=%0d addr=%h wdata=%h want 3 04 45",
                     en_n - base2, en_addr[base2], en_wdata[base2]);
        end
    endtask

    task automatic test_init_fail();
        int base, b0, e0, mid;
        RST_A_USB = 1'b1;
        tick(2);
        cfg_fail_addr = 6'h0A; cfg_fail_n = 100; cfg_gen++;
        tick(1);
        base = en_n;
        RST_A_USB = 1'b0;
        for (int i = 0; i < 400 && INIT_FAIL !== 1'b1; i++) tick(1);
        n_vec++;
        if (INIT_FAIL !== 1'b1 || INIT_DONE !== 1'b0) begin
            n_bad++;
            $display("FAIL ifail_flags: got fail=%b done=%b want 1 0", INIT_FAIL, INIT_DONE);
        end
        n_vec++;
        if (en_n - base != 5 || en_addr[base+4] !== 6'h0A) begin
            n_bad++;
            $display("FAIL ifail_attempts: got %0d last addr=%h want 5 0a", en_n - base, en_addr[base+4]);
        end
        mid = en_n; b0 = b_ack_n; e0 = b_err_n;
        B_RW = 1'b0; B_ADDR = 6'h00; B_REQ = 1'b1;
        tick(100);
        n_vec++;
        if (en_n != mid || b_ack_n != b0 || b_err_n != e0 || INIT_FAIL !== 1'b1) begin
            n_bad++;
            $display("FAIL ifail_halt: got new_en=%0d ack=%0d err=%0d fail=%b want 0 0 0 1",
                     en_n - mid, b_ack_n - b0, b_err_n - e0, INIT_FAIL);
        end
        B_REQ = 1'b0;
    endtask

    initial begin
        test_reset();
        test_init();
        test_round_robin();
        test_retry();
        test_timeout();
        test_reset_midop();
        test_init_fail();
        n_vec++;
        if (viol_n != 0) begin
            n_bad++;
            $display("FAIL protocol_violations: got %0d want 0", viol_n);
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
